// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 reading -> UART ASCII line formatter.
// Optional feature macro used by dht11_uart_formatter: DHT11_FMT_ERR_LINE_EN.
package dht11_pkg;

  localparam int unsigned MSG_LEN = 13;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV_H,
    ST_CONV_T,
    ST_SEND,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic [3:0] hun;
    logic [3:0] ten;
    logic [3:0] one;
  } bcd3_t;

  localparam logic [7:0] CH_H     = 8'h48;
  localparam logic [7:0] CH_T     = 8'h54;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_E     = 8'h45;
  localparam logic [7:0] CH_R     = 8'h52;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return CH_ZERO + {4'h0, d};
  endfunction

  // Byte at position idx of "H:ddd T:ddd\r\n" (or "H:ERR T:ERR\r\n" when err)
  function automatic logic [7:0] msg_byte(input logic [IDX_W-1:0] idx,
                                          input bcd3_t h, input bcd3_t t,
                                          input logic err);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd0:  b = CH_H;
      4'd1:  b = CH_COLON;
      4'd2:  b = err ? CH_E : digit_char(h.hun);
      4'd3:  b = err ? CH_R : digit_char(h.ten);
      4'd4:  b = err ? CH_R : digit_char(h.one);
      4'd5:  b = CH_SPACE;
      4'd6:  b = CH_T;
      4'd7:  b = CH_COLON;
      4'd8:  b = err ? CH_E : digit_char(t.hun);
      4'd9:  b = err ? CH_R : digit_char(t.ten);
      4'd10: b = err ? CH_R : digit_char(t.one);
      4'd11: b = CH_CR;
      4'd12: b = CH_LF;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dht11_uart_formatter_if.sv
// Byte stream from the formatter to the UART transmitter (valid/ready).
interface dht11_uart_formatter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/bin2bcd8.sv
// Sequential double-dabble: 8-bit binary to three BCD digits.
// One load cycle plus eight shift cycles; done pulses 9 cycles after start.
module bin2bcd8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       done,
  output logic [3:0] hun,
  output logic [3:0] ten,
  output logic [3:0] one
);

  logic [19:0] sreg;
  logic [19:0] adj;
  logic [3:0]  cnt;
  logic        active;

  // Add 3 to every BCD nibble that is 5 or more before the next shift
  always_comb begin
    adj = sreg;
    if (sreg[11:8]  >= 4'd5) adj[11:8]  = sreg[11:8]  + 4'd3;
    if (sreg[15:12] >= 4'd5) adj[15:12] = sreg[15:12] + 4'd3;
    if (sreg[19:16] >= 4'd5) adj[19:16] = sreg[19:16] + 4'd3;
  end

  // Load, then shift eight times; done is raised with the last shift
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg   <= '0;
      cnt    <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sreg   <= {12'd0, bin};
        cnt    <= 4'd8;
        active <= 1'b1;
      end else if (active) begin
        sreg <= {adj[18:0], 1'b0};
        cnt  <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign hun = sreg[19:16];
  assign ten = sreg[15:12];
  assign one = sreg[11:8];

endmodule

// File: rtl/dht11_uart_formatter.sv
// Captures a DHT11 reading, converts both bytes to decimal and streams
// "H:ddd T:ddd\r\n" to the UART TX. Optional macro DHT11_FMT_ERR_LINE_EN
// turns a bad-checksum read into an "H:ERR T:ERR\r\n" line instead of a drop.
module dht11_uart_formatter
  import dht11_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     rh_data,
  input  logic [7:0]                     t_data,
  input  logic                           dht11_done,
  input  logic                           dht11_valid,
  dht11_uart_formatter_if.master         tx,
  output logic                           busy,
  output logic                           dropped
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t           state_q, state_d;
  logic [7:0]       rh_q, rh_d;
  logic [7:0]       t_q, t_d;
  bcd3_t            hd_q, hd_d;
  bcd3_t            td_q, td_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             h_go_q, h_go_d;
  logic             err_q, err_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             busy_q, busy_d;
  logic             dropped_q, dropped_d;

  logic             conv_start_c;
  logic [7:0]       conv_bin_c;
  logic             conv_done;
  logic [3:0]       conv_hun, conv_ten, conv_one;
  bcd3_t            conv_bcd;
  logic             xfer_c;

  assign conv_bcd = {conv_hun, conv_ten, conv_one};
  assign xfer_c   = tx_valid_q & tx.tx_ready;

  bin2bcd8 u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start_c),
    .bin   (conv_bin_c),
    .done  (conv_done),
    .hun   (conv_hun),
    .ten   (conv_ten),
    .one   (conv_one)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    rh_d         = rh_q;
    t_d          = t_q;
    hd_d         = hd_q;
    td_d         = td_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    h_go_d       = 1'b0;
    err_d        = err_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    busy_d       = busy_q;
    dropped_d    = 1'b0;
    conv_start_c = 1'b0;
    conv_bin_c   = t_q;

    // First CONV_H cycle kicks the humidity conversion from the captured byte
    if (h_go_q) begin
      conv_start_c = 1'b1;
      conv_bin_c   = rh_q;
    end

    if (dht11_done && (state_q != ST_IDLE)) dropped_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (dht11_done) begin
          if (dht11_valid) begin
            rh_d    = rh_data;
            t_d     = t_data;
            err_d   = 1'b0;
            h_go_d  = 1'b1;
            busy_d  = 1'b1;
            state_d = ST_CONV_H;
          end else begin
`ifdef DHT11_FMT_ERR_LINE_EN
            err_d      = 1'b1;
            busy_d     = 1'b1;
            idx_d      = '0;
            tx_valid_d = 1'b1;
            tx_data_d  = CH_H;
            state_d    = ST_SEND;
`else
            dropped_d  = 1'b1;
`endif
          end
        end
      end
      ST_CONV_H: begin
        if (conv_done) begin
          hd_d         = conv_bcd;
          conv_start_c = 1'b1;
          conv_bin_c   = t_q;
          state_d      = ST_CONV_T;
        end
      end
      ST_CONV_T: begin
        if (conv_done) begin
          td_d       = conv_bcd;
          idx_d      = '0;
          tx_valid_d = 1'b1;
          tx_data_d  = CH_H;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (xfer_c) begin
          if (idx_q == IDX_W'(MSG_LEN - 1)) begin
            tx_valid_d = 1'b0;
            if (GAP_CYCLES == 0) begin
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end else begin
              gap_d   = '0;
              state_d = ST_GAP;
            end
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            tx_data_d = msg_byte(idx_q + IDX_W'(1), hd_q, td_q, err_q);
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rh_q       <= '0;
      t_q        <= '0;
      hd_q       <= '0;
      td_q       <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      h_go_q     <= 1'b0;
      err_q      <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rh_q       <= rh_d;
      t_q        <= t_d;
      hd_q       <= hd_d;
      td_q       <= td_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      h_go_q     <= h_go_d;
      err_q      <= err_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      dropped_q  <= dropped_d;
    end
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign busy        = busy_q;
  assign dropped     = dropped_q;

endmodule

// File: tb/tb_dht11_uart_formatter.sv
// Bench for dht11_uart_formatter: directed and random readings against a
// line model built from decimal arithmetic; second instance has GAP_CYCLES=10.
module tb_dht11_uart_formatter;

  logic       clk;
  logic       rst;
  logic [7:0] rh, t;
  logic       done, valid;
  logic       busy, dropped;
  logic       done_g, valid_g;
  logic       busy_g, dropped_g;

  dht11_uart_formatter_if tx_if ();
  dht11_uart_formatter_if tx_g ();

  dht11_uart_formatter #(.GAP_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .rh_data(rh), .t_data(t),
    .dht11_done(done), .dht11_valid(valid), .tx(tx_if),
    .busy(busy), .dropped(dropped)
  );

  dht11_uart_formatter #(.GAP_CYCLES(10)) dut_g (
    .clk(clk), .rst(rst), .rh_data(rh), .t_data(t),
    .dht11_done(done_g), .dht11_valid(valid_g), .tx(tx_g),
    .busy(busy_g), .dropped(dropped_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int first_cyc, last_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] dch(input int v);
    return 8'(32'h30 + v);
  endfunction

  // Expected line straight from the message format
  task automatic build_exp(input int h, input int tv, input bit err);
    exp_q.delete();
    exp_q.push_back(8'h48); exp_q.push_back(8'h3A);
    if (err) begin exp_q.push_back(8'h45); exp_q.push_back(8'h52); exp_q.push_back(8'h52); end
    else begin exp_q.push_back(dch(h / 100)); exp_q.push_back(dch((h / 10) % 10)); exp_q.push_back(dch(h % 10)); end
    exp_q.push_back(8'h20); exp_q.push_back(8'h54); exp_q.push_back(8'h3A);
    if (err) begin exp_q.push_back(8'h45); exp_q.push_back(8'h52); exp_q.push_back(8'h52); end
    else begin exp_q.push_back(dch(tv / 100)); exp_q.push_back(dch((tv / 10) % 10)); exp_q.push_back(dch(tv % 10)); end
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
  endtask

  task automatic send_read(input logic [7:0] a, input logic [7:0] b, input logic v);
    rh = a; t = b; valid = v; done = 1'b1;
    step();
    done = 1'b0; valid = 1'b0;
  endtask

  // Cycles from the done cycle until tx_valid is first seen
  task automatic wait_first(input string tag);
    int n;
    n = 1;
    while (!tx_if.tx_valid && n < 40) begin step(); n++; end
    check({tag, "_latency_ok"}, 32'(n <= 20), 32'd1);
  endtask

  // mode 0: ready always; 1: ready every third cycle; 2: random ready
  task automatic collect(input int mode, input int stop_at, input int inj_at);
    int cyc, inj;
    bit stalled, r;
    logic [7:0] held;
    got_q.delete();
    cyc = 0; inj = 0; stalled = 0; held = 8'h00; first_cyc = -1; last_cyc = -1;
    while (got_q.size() < stop_at && cyc < 400) begin
      if (inj == 1) begin
        done = 1'b0; valid = 1'b0;
        check("drop_pulse", 32'(dropped), 32'd1);
        inj = 2;
      end else if (inj == 2) begin
        check("drop_single", 32'(dropped), 32'd0);
        inj = 3;
      end
      if (inj == 0 && inj_at >= 0 && got_q.size() == inj_at) begin
        rh = 8'd99; t = 8'd99; valid = 1'b1; done = 1'b1; inj = 1;
      end
      case (mode)
        0: r = 1'b1;
        1: r = (cyc % 3 == 2);
        default: r = ($urandom_range(0, 2) == 0);
      endcase
      tx_if.tx_ready = r;
      if (stalled) begin
        check("hold_valid", 32'(tx_if.tx_valid), 32'd1);
        check("hold_data", 32'(tx_if.tx_data), 32'(held));
      end
      stalled = tx_if.tx_valid && !r;
      held = tx_if.tx_data;
      if (tx_if.tx_valid && r) begin
        got_q.push_back(tx_if.tx_data);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      step();
      cyc++;
    end
    tx_if.tx_ready = 1'b1;
  endtask

  task automatic compare_line(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_valid_drop"}, 32'(tx_if.tx_valid), 32'd0);
  endtask

  task automatic full_line(input string tag, input logic [7:0] a, input logic [7:0] b, input int mode);
    build_exp(int'(a), int'(b), 1'b0);
    send_read(a, b, 1'b1);
    check({tag, "_nodrop"}, 32'(dropped), 32'd0);
    wait_first(tag);
    collect(mode, 13, -1);
    compare_line(tag);
    if (mode == 0) check({tag, "_contig"}, 32'(last_cyc - first_cyc + 1), 32'd13);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nv, n;
    bit found;
    rst = 1'b0; rh = 8'h00; t = 8'h00; done = 1'b0; valid = 1'b0;
    done_g = 1'b0; valid_g = 1'b0;
    tx_if.tx_ready = 1'b1; tx_g.tx_ready = 1'b1;
    step(); step(); step();
    check("rst_tx_data", 32'(tx_if.tx_data), 32'h00);
    check("rst_tx_valid", 32'(tx_if.tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
    rst = 1'b1;
    step();

    full_line("l170_198", 8'd170, 8'd198, 0);
    step();
    full_line("l005_000", 8'd5, 8'd0, 1);
    step();
    for (int k = 0; k < 6; k++) begin
      full_line($sformatf("rnd%0d", k), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2);
      step();
    end
    full_line("l000_255", 8'd0, 8'd255, 2);
    step();

    // Second read arriving mid-line is dropped and changes nothing
    build_exp(42, 77, 1'b0);
    send_read(8'd42, 8'd77, 1'b1);
    wait_first("inj");
    collect(0, 13, 3);
    compare_line("inj");
    nv = 0;
    for (int i = 0; i < 30; i++) begin if (tx_if.tx_valid) nv++; step(); end
    check("inj_no_second", 32'(nv), 32'd0);

    // Bad checksum read
`ifdef DHT11_FMT_ERR_LINE_EN
    build_exp(0, 0, 1'b1);
    send_read(8'd255, 8'd3, 1'b0);
    check("bad_nodrop", 32'(dropped), 32'd0);
    wait_first("err");
    collect(2, 13, -1);
    compare_line("err");
`else
    send_read(8'd255, 8'd3, 1'b0);
    check("bad_drop", 32'(dropped), 32'd1);
    nv = 0;
    for (int i = 0; i < 25; i++) begin if (tx_if.tx_valid || busy) nv++; step(); end
    check("bad_silent", 32'(nv), 32'd0);
    check("bad_drop_end", 32'(dropped), 32'd0);
`endif
    step();

    // Reset in the middle of a line, then a clean 255/255 line
    send_read(8'd1, 8'd2, 1'b1);
    wait_first("mid");
    collect(0, 4, -1);
    check("mid_got4", 32'(got_q.size()), 32'd4);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(tx_if.tx_valid), 32'd0);
    check("mid_rst_data", 32'(tx_if.tx_data), 32'h00);
    check("mid_rst_busy", 32'(busy), 32'd0);
    step(); step();
    rst = 1'b1;
    nv = 0;
    for (int i = 0; i < 20; i++) begin if (tx_if.tx_valid) nv++; step(); end
    check("mid_no_resume", 32'(nv), 32'd0);
    full_line("l255_255", 8'd255, 8'd255, 0);

    // GAP_CYCLES=10 instance: busy holds after LF, reads in the gap drop
    rh = 8'd12; t = 8'd34; valid_g = 1'b1; done_g = 1'b1;
    step();
    done_g = 1'b0; valid_g = 1'b0;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (tx_g.tx_valid && tx_g.tx_data == 8'h0A) found = 1;
      step();
    end
    check("gap_lf_seen", 32'(found), 32'd1);
    n = 0;
    while (busy_g && n < 30) begin
      if (n == 4) begin rh = 8'd55; valid_g = 1'b1; done_g = 1'b1; end
      else if (n == 5) begin
        done_g = 1'b0; valid_g = 1'b0;
        check("gap_drop", 32'(dropped_g), 32'd1);
      end
      step();
      n++;
    end
    check("gap_busy_len", 32'(n), 32'd10);
    check("gap_valid_low", 32'(tx_g.tx_valid), 32'd0);
    rh = 8'd7; t = 8'd8; valid_g = 1'b1; done_g = 1'b1;
    step();
    done_g = 1'b0; valid_g = 1'b0;
    n = 1;
    while (!tx_g.tx_valid && n < 40) begin step(); n++; end
    check("gap_next_latency_ok", 32'(n <= 20), 32'd1);
    check("gap_next_first", 32'(tx_g.tx_data), 32'h48);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
